// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional perf counters are enabled by the FETCH_PERF_CNT_EN macro.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port: word address out, combinational data back.
interface instruction_fetch_unit_if;

    logic [31:0] ImemAddr;
    logic [31:0] ImemInstr;

    modport master (output ImemAddr, input ImemInstr);
    modport slave  (input ImemAddr, output ImemInstr);

endinterface

// File: rtl/instruction_fetch_unit_ifid_register.sv
// IF/ID pipeline register: flush inserts a bubble, enable captures a fetch.
module ifid_register
    import instruction_fetch_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        i_en,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pcplus4;
    logic        r_valid;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_instr   <= NOP;
            r_pcplus4 <= '0;
            r_valid   <= 1'b0;
        end else if (i_flush) begin
            r_instr   <= NOP;
            r_pcplus4 <= '0;
            r_valid   <= 1'b0;
        end else if (i_en) begin
            r_instr   <= i_instr;
            r_pcplus4 <= i_pcplus4;
            r_valid   <= 1'b1;
        end
    end

    assign o_instr   = r_instr;
    assign o_pcplus4 = r_pcplus4;
    assign o_valid   = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, BOOT/RUN/HOLD FSM, redirect priority and IF/ID.
// Define FETCH_PERF_CNT_EN to add FetchCount/StallCount/FlushCount outputs.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
)(
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Stall,
    input  logic                     BranchTaken,
    input  logic [31:0]              BranchTarget,
    input  logic                     JumpTaken,
    input  logic [31:0]              JumpTarget,
    instruction_fetch_unit_if.master imem,
    output logic [31:0]              IFID_Instr,
    output logic [31:0]              IFID_PCPlus4,
    output logic                     IFID_Valid,
    output logic [31:0]              PC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              FetchCount,
    output logic [31:0]              StallCount,
    output logic [31:0]              FlushCount
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  w_next_pc;
    logic [31:0]  w_pcplus4;
    logic [31:0]  w_word;
    logic [31:0]  w_target;
    logic         w_redirect;
    logic         w_en;
    logic         w_flush;

    assign w_pcplus4  = r_pc + PC_INC;
    assign w_word     = {2'b00, r_pc[31:2]};
    assign w_redirect = JumpTaken | BranchTaken;
    assign w_target   = align_word(JumpTaken ? JumpTarget : BranchTarget);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    // BOOT always bubbles; a redirect then wins over Stall in every state
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_en         = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            BOOT: begin
                w_flush      = 1'b1;
                w_next_state = RUN;
                if (w_redirect) w_next_pc = w_target;
            end
            RUN, HOLD: begin
                if (w_redirect) begin
                    w_flush      = 1'b1;
                    w_next_pc    = w_target;
                    w_next_state = RUN;
                end else if (Stall) begin
                    w_next_state = HOLD;
                end else begin
                    w_en         = 1'b1;
                    w_next_pc    = w_pcplus4;
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = BOOT;
                w_next_pc    = RESET_PC;
                w_flush      = 1'b1;
            end
        endcase
    end

    ifid_register u_ifid (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_en      (w_en),
        .i_flush   (w_flush),
        .i_instr   (imem.ImemInstr),
        .i_pcplus4 (w_pcplus4),
        .o_instr   (IFID_Instr),
        .o_pcplus4 (IFID_PCPlus4),
        .o_valid   (IFID_Valid)
    );

    assign imem.ImemAddr = w_word % 32'(IMEM_WORDS);
    assign PC            = r_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_hold;

    assign w_hold = (w_next_state == HOLD);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_en && r_fetch_cnt != '1)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_hold && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_redirect && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign FetchCount = r_fetch_cnt;
    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a behavioural model.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        JumpTaken;
    logic [31:0] JumpTarget;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] PC;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
    logic [31:0] FlushCount;
`endif

    logic [31:0] mem [0:1023];
    int vectors = 0;
    int errors  = 0;

    // behavioural model of the visible fetch state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_boot;
    logic [31:0] m_fetch, m_stall, m_flush;

    instruction_fetch_unit_if imem ();

    assign imem.ImemInstr = mem[imem.ImemAddr[9:0]];

    always #5 Clk = ~Clk;

    instruction_fetch_unit dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .JumpTaken    (JumpTaken),
        .JumpTarget   (JumpTarget),
        .imem         (imem.master),
        .IFID_Instr   (IFID_Instr),
        .IFID_PCPlus4 (IFID_PCPlus4),
        .IFID_Valid   (IFID_Valid),
        .PC           (PC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount   (FetchCount),
        .StallCount   (StallCount),
        .FlushCount   (FlushCount)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        return (pc >> 2) % 1024;
    endfunction

    task automatic model_edge(input logic rst, input logic st,
                              input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt);
        logic [31:0] tgt;
        tgt = jp ? jt : bt;
        tgt[1:0] = 2'b00;
        if (!rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_boot = 1'b1;
            m_fetch = 0; m_stall = 0; m_flush = 0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_valid = 1'b0; m_instr = 32'h0;
            if (jp || br) begin
                m_pc = tgt;
                if (m_flush != 32'hFFFF_FFFF) m_flush++;
            end
        end else if (jp || br) begin
            m_pc = tgt;
            m_valid = 1'b0; m_instr = 32'h0;
            if (m_flush != 32'hFFFF_FFFF) m_flush++;
        end else if (st) begin
            if (m_stall != 32'hFFFF_FFFF) m_stall++;
        end else begin
            m_instr = mem[model_word(m_pc)];
            m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
        end
    endtask

    task automatic tick(input logic rst, input logic st,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
        @(negedge Clk);
        Rst = rst; Stall = st;
        BranchTaken = br; BranchTarget = bt;
        JumpTaken = jp; JumpTarget = jt;
        model_edge(rst, st, br, bt, jp, jt);
        @(posedge Clk);
        #1;
        chk("pc", PC, m_pc);
        chk("imem_addr", imem.ImemAddr, model_word(m_pc));
        chk("valid", {31'd0, IFID_Valid}, {31'd0, m_valid});
        chk("instr", IFID_Instr, m_instr);
        if (m_valid) chk("pcplus4", IFID_PCPlus4, m_pc4);
        if (!rst) chk("pcplus4_rst", IFID_PCPlus4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", FetchCount, m_fetch);
        chk("stall_cnt", StallCount, m_stall);
        chk("flush_cnt", FlushCount, m_flush);
`endif
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Rst = 0; Stall = 0;
        BranchTaken = 0; BranchTarget = 0;
        JumpTaken = 0; JumpTarget = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22;
        mem[2] = 32'h33; mem[3] = 32'h44;

        tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 1, 32'h40, 1, 32'h80);

        // boot bubble, then 0x11 and 0x22, PC lands on 8
        free(3);
        chk("boot_seq_pc", PC, 32'h8);
        chk("boot_seq_instr", IFID_Instr, 32'h22);

        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0, 0);
        chk("stall_pc", PC, 32'h8);
        chk("stall_pc4", IFID_PCPlus4, 32'h8);

        free(1);
        chk("after_stall", IFID_Instr, 32'h33);
        chk("after_stall_pc4", IFID_PCPlus4, 32'hC);

        tick(1, 0, 1, 32'h40, 0, 0);
        free(1);
        chk("branch_fetch", IFID_Instr, mem[16]);

        tick(1, 1, 0, 0, 0, 0);
        tick(1, 1, 1, 32'h40, 1, 32'h80);
        chk("jump_pc", PC, 32'h80);
        free(1);

        tick(1, 0, 0, 0, 1, 32'hFFE);
        chk("wrap_addr_hi", imem.ImemAddr, 32'd1023);
        free(1);
        chk("wrap_addr_lo", imem.ImemAddr, 32'd0);
        chk("wrap_pc", PC, 32'h1000);

        tick(1, 1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        chk("rst_mid_hold", PC, 32'h0);
        free(2);

        for (int i = 0; i < 3000; i++) begin
            logic r, s, b, j;
            logic [31:0] bt, jt;
            r  = ($urandom_range(0, 99) != 0);
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 11) == 0);
            j  = ($urandom_range(0, 15) == 0);
            bt = $urandom;
            jt = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 8191);
            tick(r, s, b, bt, j, jt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address loaded into the program counter (PC) on reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 1024, instruction-memory depth in 32-bit words.
REQ-003 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port Rst, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port Stall, input, 1, hazard unit request to hold PC and IF/ID.
REQ-006 SHALL have port BranchTaken, input, 1, resolved taken branch.
REQ-007 SHALL have port BranchTarget, input, 32, branch byte address.
REQ-008 SHALL have port JumpTaken, input, 1, jump/jr request.
REQ-009 SHALL have port JumpTarget, input, 32, jump byte address.
REQ-010 SHALL have port ImemAddr, output, 32, word index to instruction memory, equal to PC[31:2] zero-extended.
REQ-011 SHALL have port ImemInstr, input, 32, combinational read data for ImemAddr.
REQ-012 SHALL have port IFID_Instr, output, 32, registered instruction.
REQ-013 SHALL have port IFID_PCPlus4, output, 32, registered PC+4 of that instruction.
REQ-014 SHALL have port IFID_Valid, output, 1, IF/ID holds a real instruction.
REQ-015 SHALL have port PC, output, 32, current fetch byte address.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, HOLD; BOOT entered on reset, left unconditionally to RUN after one cycle.
REQ-017 In BOOT, SHALL present ImemAddr for RESET_PC and load IF/ID with a bubble (IFID_Valid=0, IFID_Instr=0).
REQ-018 In RUN with no redirect and no Stall, SHALL per cycle latch ImemInstr into IFID_Instr, PC+4 into IFID_PCPlus4, set IFID_Valid=1, and advance PC by 4.
REQ-019 Fetch latency SHALL be exactly one cycle from PC presentation to IF/ID capture.
REQ-020 Redirect priority SHALL be JumpTaken > BranchTaken > Stall > sequential.
REQ-021 On a redirect, SHALL load PC with the selected target and flush IF/ID to a bubble on the same edge, staying in or returning to RUN.
REQ-022 Redirect asserted during HOLD SHALL take effect (redirect overrides Stall) and transition to RUN.
REQ-023 Stall with no redirect SHALL hold PC, IFID_Instr, IFID_PCPlus4, IFID_Valid unchanged and enter HOLD; deassertion returns to RUN.
REQ-024 Stall asserted in BOOT SHALL be ignored.
REQ-025 PC arithmetic SHALL be modulo 2^32; target bits [1:0] SHALL be forced to 0 when loaded.
REQ-026 ImemAddr SHALL wrap modulo IMEM_WORDS (PC 4*IMEM_WORDS maps to word 0).

Reset
REQ-027 With Rst=0 at a rising edge: PC=RESET_PC, IFID_Instr=0, IFID_PCPlus4=0, IFID_Valid=0, state=BOOT, counters=0.
REQ-028 Reset SHALL override every other input, including mid-stall and mid-redirect.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN SHALL, when defined, add 32-bit outputs FetchCount (valid captures), StallCount (HOLD cycles), FlushCount (redirects), each saturating at 32'hFFFF_FFFF.
REQ-030 Without FETCH_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold the FSM state typedef (BOOT/RUN/HOLD), NOP encoding 32'h0, and PC increment constant 4.
REQ-032 SHALL contain one sub-module, ifid_register, holding the IF/ID fields with enable (not Stall) and flush inputs.

Verification
REQ-033 Reset then 4 free cycles, memory words 0..3 = 0x11,0x22,0x33,0x44 -> cycle 1 bubble; cycles 2-4 IFID_Instr 0x11,0x22,0x33 with IFID_PCPlus4 4,8,12.
REQ-034 Stall high 3 cycles at PC=8 -> PC stays 8, IF/ID unchanged, StallCount=3 if enabled.
REQ-035 BranchTaken=1, BranchTarget=0x40 at PC=12 -> next PC 0x40, IFID_Valid=0, following cycle IFID_Instr=mem[16].
REQ-036 JumpTaken=1 (0x80) and BranchTaken=1 (0x40) together during Stall -> PC=0x80, bubble, state RUN.
REQ-037 PC=0xFFC, no stall -> ImemAddr 1023 then 0 with PC 0x1000.
REQ-038 Rst=0 asserted mid-HOLD -> PC=RESET_PC, IFID_Valid=0, state BOOT next edge.
